// File: rtl/menu_vtiming.sv
// menu_vtiming: parametrised raster timing generator with NTSC/PAL, scandoubled and interlaced line tables
module menu_vtiming #(
    parameter int HW       = 10,
    parameter int VW       = 10,
    parameter int HTOTAL   = 640,
    parameter int HBL      = 550,
    parameter int HS_START = 570,
    parameter int HS_END   = 602,
    parameter int CE_DIV   = 2,
    parameter int FCW      = 8
) (
    input  logic           clk_sys,
    input  logic           RESET,
    input  logic           pal,
    input  logic           dbl,
    input  logic           interlace,
    output logic           ce_pix,
    output logic [HW-1:0]  hc,
    output logic [VW-1:0]  vc,
    output logic           hblank,
    output logic           vblank,
    output logic           hsync,
    output logic           vsync,
    output logic           de,
    output logic           field,
    output logic [FCW-1:0] frame_cnt,
    output logic           sof
);
    localparam int CW = $clog2(CE_DIV);

    logic [CW-1:0] ce_cnt;
    logic          ce_wrap;
    logic          mode_pal;
    logic          mode_dbl;
    logic          mode_int;
    logic [VW-1:0] vtotal;
    logic [VW-1:0] vbl;
    logic [VW-1:0] vs_start;
    logic [VW-1:0] vs_end;
    logic [VW-1:0] v_last;
    logic [VW-1:0] vc_nxt;
    logic [HW-1:0] hc_nxt;
    logic          h_end;
    logic          eof;

    // Line table for the latched mode, plus next-position and end-of-frame decode
    always_comb begin
        vtotal   = mode_dbl ? (mode_pal ? VW'(624) : VW'(524)) : (mode_pal ? VW'(312) : VW'(262));
        vbl      = mode_dbl ? (mode_pal ? VW'(601) : VW'(480)) : (mode_pal ? VW'(300) : VW'(240));
        vs_start = mode_dbl ? (mode_pal ? VW'(609) : VW'(490)) : (mode_pal ? VW'(304) : VW'(245));
        vs_end   = mode_dbl ? (mode_pal ? VW'(617) : VW'(496)) : (mode_pal ? VW'(308) : VW'(248));
        v_last   = vtotal - VW'(1) + VW'(mode_int & ~mode_dbl & field);
        h_end    = hc == HW'(HTOTAL - 1);
        eof      = ce_pix & h_end & (vc == v_last);
        hc_nxt   = h_end ? '0 : hc + 1'b1;
        vc_nxt   = h_end ? ((vc == v_last) ? '0 : vc + 1'b1) : vc;
        ce_wrap  = ce_cnt == CW'(CE_DIV - 1);
    end

    // Pixel divider: every clock when doubled, otherwise one pulse per CE_DIV clocks
    always_ff @(posedge clk_sys) begin
        if (!RESET) begin
            ce_cnt <= '0;
            ce_pix <= 1'b0;
        end else begin
            ce_pix <= mode_dbl | ce_wrap;
            ce_cnt <= (mode_dbl | ce_wrap) ? '0 : ce_cnt + 1'b1;
        end
    end

    // Raster counters and flags, flags computed from the position being entered
    always_ff @(posedge clk_sys) begin
        if (!RESET) begin
            hc     <= '0;
            vc     <= '0;
            hblank <= 1'b0;
            hsync  <= 1'b0;
            vblank <= 1'b0;
            vsync  <= 1'b0;
        end else if (ce_pix) begin
            hc     <= hc_nxt;
            vc     <= vc_nxt;
            hblank <= hc_nxt >= HW'(HBL);
            hsync  <= (hc_nxt >= HW'(HS_START)) && (hc_nxt < HW'(HS_END));
            vblank <= vc_nxt >= vbl;
            vsync  <= (vc_nxt >= vs_start) && (vc_nxt < vs_end);
        end
    end

    // Frame boundary: pulse sof, count the frame, flip the field and latch the next mode
    always_ff @(posedge clk_sys) begin
        if (!RESET) begin
            sof       <= 1'b0;
            frame_cnt <= '0;
            field     <= 1'b0;
            mode_pal  <= pal;
            mode_dbl  <= dbl;
            mode_int  <= interlace;
        end else begin
            sof <= eof;
            if (eof) begin
                frame_cnt <= frame_cnt + 1'b1;
                field     <= interlace & ~dbl & ~field;
                mode_pal  <= pal;
                mode_dbl  <= dbl;
                mode_int  <= interlace;
            end
        end
    end

    assign de = ~(hblank | vblank);

endmodule

// File: tb/tb_menu_vtiming.sv
// tb_menu_vtiming: randomized-input bench for menu_vtiming against a frame-level reference model
module tb_menu_vtiming;
    localparam int HW  = 10;
    localparam int VW  = 10;
    localparam int HT  = 16;
    localparam int HB  = 12;
    localparam int HS  = 13;
    localparam int HE  = 15;
    localparam int CD  = 2;
    localparam int FCW = 2;

    logic           clk;
    logic           RESET;
    logic           pal;
    logic           dbl;
    logic           interlace;
    logic           ce_pix;
    logic [HW-1:0]  hc;
    logic [VW-1:0]  vc;
    logic           hblank;
    logic           vblank;
    logic           hsync;
    logic           vsync;
    logic           de;
    logic           field;
    logic [FCW-1:0] frame_cnt;
    logic           sof;

    menu_vtiming #(
        .HW(HW), .VW(VW), .HTOTAL(HT), .HBL(HB), .HS_START(HS), .HS_END(HE), .CE_DIV(CD), .FCW(FCW)
    ) dut (
        .clk_sys(clk), .RESET(RESET), .pal(pal), .dbl(dbl), .interlace(interlace),
        .ce_pix(ce_pix), .hc(hc), .vc(vc), .hblank(hblank), .vblank(vblank),
        .hsync(hsync), .vsync(vsync), .de(de), .field(field), .frame_cnt(frame_cnt), .sof(sof)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_sof = 0;
    int len;

    // VTOTAL, VBL, VS_START, VS_END indexed by {dbl, pal}
    int tbl[4][4] = '{'{262, 240, 245, 248}, '{312, 300, 304, 308},
                      '{524, 480, 490, 496}, '{624, 601, 609, 617}};

    bit m_valid = 0;
    int m_hc, m_vc, m_ph, m_fc;
    bit m_ce, m_hb, m_vb, m_hs, m_vs, m_field, m_sof, m_pal, m_dbl, m_int;

    initial clk = 0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference model: raster position advanced one pixel per enabled clock, mode latched per frame
    initial forever begin
        int row, lines;
        bit eof, ce_n;
        @(posedge clk);
        if (!RESET) begin
            m_valid = 1;
            m_hc = 0; m_vc = 0; m_ph = 0; m_fc = 0;
            m_ce = 0; m_hb = 0; m_vb = 0; m_hs = 0; m_vs = 0; m_field = 0; m_sof = 0;
            m_pal = pal; m_dbl = dbl; m_int = interlace;
        end else begin
            row   = (m_dbl ? 2 : 0) + (m_pal ? 1 : 0);
            lines = tbl[row][0] + ((m_int && !m_dbl && m_field) ? 1 : 0);
            eof   = m_ce && m_hc == HT - 1 && m_vc == lines - 1;
            ce_n  = m_dbl || m_ph == CD - 1;
            m_ph  = ce_n ? 0 : m_ph + 1;
            m_sof = eof;
            if (m_ce) begin
                m_hc = (m_hc + 1) % HT;
                if (m_hc == 0) m_vc = (m_vc + 1) % lines;
                m_hb = m_hc >= HB;
                m_hs = m_hc >= HS && m_hc < HE;
                m_vb = m_vc >= tbl[row][1];
                m_vs = m_vc >= tbl[row][2] && m_vc < tbl[row][3];
            end
            m_ce = ce_n;
            if (eof) begin
                m_fc    = (m_fc + 1) % (1 << FCW);
                m_field = (interlace && !dbl) ? !m_field : 1'b0;
                m_pal   = pal; m_dbl = dbl; m_int = interlace;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    initial forever begin
        logic [29:0] got, exp;
        @(negedge clk);
        if (m_valid) begin
            got = {ce_pix, hc, vc, hblank, vblank, hsync, vsync, de, field, frame_cnt, sof};
            exp = {m_ce, HW'(m_hc), VW'(m_vc), m_hb, m_vb, m_hs, m_vs, !(m_hb || m_vb), m_field, FCW'(m_fc), m_sof};
            tests++;
            if (got !== exp) begin
                fails++;
                if (fails <= 20)
                    $display("FAIL outputs cycle %0d: got %h expected %h (hc=%0d vc=%0d, model hc=%0d vc=%0d)",
                             cyc, got, exp, hc, vc, m_hc, m_vc);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic glitch(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            if ($urandom_range(0, 15) == 0) {pal, dbl, interlace} = 3'($urandom);
        end
    endtask

    task automatic set_mode(input logic p, input logic d, input logic i);
        pal = p;
        dbl = d;
        interlace = i;
    endtask

    task automatic wait_pos(input int h, input int v);
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (hc == HW'(h) && vc == VW'(v)) return;
        end
        tests++;
        fails++;
        $display("FAIL wait_pos timeout: never reached hc=%0d vc=%0d", h, v);
    endtask

    task automatic wait_sof(output int n);
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (sof) begin
                n = cyc - last_sof;
                last_sof = cyc;
                @(negedge clk);
                chk("sof_width", sof, 0);
                return;
            end
        end
        n = -1;
        tests++;
        fails++;
        $display("FAIL wait_sof timeout: no sof within bound");
    endtask

    initial begin
        RESET = 0;
        set_mode(0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hc", hc, 0);
        chk("rst_vc", vc, 0);
        chk("rst_ce", ce_pix, 0);
        chk("rst_de", de, 1);
        chk("rst_hblank", hblank, 0);
        chk("rst_fc", frame_cnt, 0);
        chk("rst_sof", sof, 0);
        @(posedge clk);
        #2 RESET = 1;
        last_sof = cyc;
        tick;
        chk("ce_clk1", ce_pix, 0);
        tick;
        chk("ce_clk2", ce_pix, 1);

        // Frame A: NTSC, pal raised at vc=100 only affects the next frame
        glitch(2000);
        wait_pos(0, 100);
        @(posedge clk);
        #2 set_mode(1, 0, 0);
        wait_sof(len);
        chk("fc_A", frame_cnt, 1);

        // Frame B: PAL normal
        glitch(2000);
        set_mode(1, 1, 0);
        wait_pos(HB, 100);
        chk("hblank_at_HBL", hblank, 1);
        wait_pos(HE - 1, 100);
        chk("hsync_last", hsync, 1);
        wait_pos(HT - 1, 100);
        chk("hsync_after", hsync, 0);
        wait_sof(len);
        chk("len_B", len, HT * 312 * CD);
        chk("fc_B", frame_cnt, 2);

        // Frame C: PAL doubled, entered from normal
        glitch(2000);
        set_mode(1, 1, 0);
        wait_sof(len);
        chk("fc_C", frame_cnt, 3);

        // Frame D: PAL doubled steady state
        glitch(2000);
        set_mode(0, 0, 1);
        chk("dbl_ce", ce_pix, 1);
        wait_pos(0, 600);
        chk("vblank_600", vblank, 0);
        wait_pos(0, 601);
        chk("vblank_601", vblank, 1);
        wait_pos(0, 609);
        chk("vsync_609", vsync, 1);
        wait_pos(0, 617);
        chk("vsync_617", vsync, 0);
        wait_sof(len);
        chk("len_D", len, HT * 624);
        chk("fc_D", frame_cnt, 0);
        chk("field_E", field, 1);

        // Frames E/F/G: NTSC interlaced, alternating field lengths
        glitch(1000);
        set_mode(0, 0, 1);
        wait_sof(len);
        chk("fc_E", frame_cnt, 1);
        chk("field_F", field, 0);
        glitch(1000);
        set_mode(0, 0, 1);
        wait_sof(len);
        chk("len_F", len, HT * 262 * CD);
        chk("field_G", field, 1);
        glitch(2000);
        set_mode(0, 0, 1);
        wait_pos(0, 262);
        chk("odd_extra_vblank", vblank, 1);
        chk("odd_extra_de", de, 0);
        wait_sof(len);
        chk("len_G", len, HT * 263 * CD);
        chk("fc_G", frame_cnt, 3);
        chk("field_H", field, 0);

        // Mid-frame reset for one clock
        set_mode(0, 0, 0);
        wait_pos(10, 50);
        @(posedge clk);
        #2 RESET = 0;
        @(posedge clk);
        #2 RESET = 1;
        @(negedge clk);
        chk("mid_rst_hc", hc, 0);
        chk("mid_rst_vc", vc, 0);
        chk("mid_rst_ce", ce_pix, 0);
        chk("mid_rst_fc", frame_cnt, 0);
        chk("mid_rst_de", de, 1);
        tick;
        chk("mid_ce_clk1", ce_pix, 0);
        tick;
        chk("mid_ce_clk2", ce_pix, 1);
        repeat (200) tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/menu_vtiming.md
Name: menu_vtiming

Overview:
- Parametrised raster timing generator for the menu core; successor to the fixed 640-pixel NTSC/PAL counter.
- Produces the pixel enable, H/V counters, blank/sync/DE, field flag, frame counter and start-of-frame pulse. The pattern generators and the video output consume these.
- Adds a configurable horizontal geometry and pixel divider.
- Adds 480i/576i interlace with alternating field lengths.
- Mode changes are applied only at frame boundaries, so no torn frames are emitted.

Parameters:
- HW, 10: width of hc.
- VW, 10: width of vc.
- HTOTAL, 640: pixels per line; hc counts 0..HTOTAL-1.
- HBL, 550: first hblank pixel.
- HS_START, 570: first hsync pixel.
- HS_END, 602: first pixel after hsync.
- CE_DIV, 2: clk_sys cycles per pixel when not doubled; must be ≥2.
- FCW, 8: frame counter width.

Ports:
- clk_sys  in  1  system/video clock.
- RESET  in  1  synchronous, active-low reset.
- pal  in  1  PAL line table when 1, NTSC when 0.
- dbl  in  1  scandoubled mode: ce every clock, doubled line table.
- interlace  in  1  interlaced fields; ignored when dbl=1.
- ce_pix  out  1  pixel enable.
- hc  out  HW  horizontal counter.
- vc  out  VW  vertical counter.
- hblank  out  1  horizontal blank.
- vblank  out  1  vertical blank.
- hsync  out  1  horizontal sync, active-high.
- vsync  out  1  vertical sync, active-high.
- de  out  1  ~(hblank|vblank).
- field  out  1  current field: 0 even, 1 odd.
- frame_cnt  out  FCW  completed frames, wraps modulo 2^FCW.
- sof  out  1  one-clk pulse when counters move to (0,0).

Behaviour:
- Clock and reset: all state is in clk_sys.
- Reset (RESET=0 at a clock edge) sets:
  - hc=0, vc=0, ce_cnt=0, ce_pix=0;
  - hblank=vblank=hsync=vsync=0, de=1;
  - field=0, frame_cnt=0, sof=0;
  - mode registers loaded from pal/dbl/interlace.
- Reset asserted mid-frame aborts the frame immediately; there is no partial-frame count.
- Pixel divider, doubled mode (mode_dbl=1): ce_pix=1 on every non-reset cycle.
- Pixel divider, normal mode:
  - ce_cnt runs 0..CE_DIV-1 and wraps.
  - ce_pix is registered, =1 on the cycle following ce_cnt==CE_DIV-1; the first ce_pix after reset occurs on clock CE_DIV.
- Counter advance: counters and flags advance only on clocks where ce_pix=1 (registered value).
  - hc==HTOTAL-1: hc→0 and the line increments.
  - Otherwise hc+1.
  - At the last line, vc→0 (end of frame).
- Line table (VTOTAL / VBL / VS_START / VS_END), chosen by the mode registers:
  - NTSC: 262/240/245/248.
  - PAL: 312/300/304/308.
  - NTSC dbl: 524/480/490/496.
  - PAL dbl: 624/601/609/617.
- Interlace (mode_int=1 and mode_dbl=0):
  - field=1 frames have VTOTAL+1 lines; the extra line is inside vblank.
  - field toggles at each end of frame.
  - Otherwise field is held at 0.
- Flags are registered and updated on the same ce_pix edge as the counters, so they always describe the new hc/vc:
  - hblank = hc∈[HBL, HTOTAL-1].
  - hsync = hc∈[HS_START, HS_END-1].
  - vblank = vc∈[VBL, last line].
  - vsync = vc∈[VS_START, VS_END-1].
  - de = ~(hblank|vblank), same cycle.
- End of frame, on the ce_pix edge that takes the counters to (0,0):
  - sof=1 for exactly that clk_sys cycle.
  - frame_cnt increments and wraps from 2^FCW-1 to 0.
  - pal/dbl/interlace are sampled into the mode registers.
- The new mode, including the ce divider rate, governs the whole next frame.
- Input changes during a frame have no effect until the end of that frame.
- Simultaneous events:
  - A dbl change sampled at end of frame takes effect from the next clock; ce_cnt restarts at 0.
  - Reset has priority over everything.

Test Plan:
- Reset, then NTSC, CE_DIV=2, dbl=0 → ce_pix period 2 clocks; hc wraps 639→0; vc wraps 261→0; sof every 640*262*2=335,360 clocks; hblank asserts at hc=550; hsync high for hc 570..601.
- PAL with dbl=1 → ce_pix constant 1; frame = 640*624 clocks; vblank asserts at vc=601; vsync high for vc 609..616.
- NTSC with interlace=1 → frames alternate 262/263 lines; field toggles 0,1,0; line 262 of the odd field has vblank=1 and de=0.
- Toggle pal at vc=100 of an NTSC frame → that frame still ends after line 261; the next frame is 312 lines; frame_cnt increments once.
- Assert RESET=0 at hc=300, vc=50 for 1 clock → next cycle all outputs are at reset values; ce_pix first returns 2 clocks later.
- FCW=2, run 5 frames → frame_cnt sequence 1,2,3,0,1; sof pulses are exactly 1 clock wide.
